// File: rtl/alu_vector_recorder_if.sv
// Bus bundle for the ALU test-vector recorder: sweep control, ALU operand
// and result lines, record write strobe and memory read port.
interface alu_vector_recorder_if;
  logic        start;
  logic        abort;
  logic [3:0]  I0;
  logic [3:0]  I1;
  logic [1:0]  C;
  logic [3:0]  alu_out;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [13:0] wr_data;
  logic [7:0]  rd_addr;
  logic [13:0] rd_data;

  // Environment side: controller plus the ALU under test.
  modport master (
    output start, abort, alu_out, rd_addr,
    input  I0, I1, C, busy, done, wr_en, wr_addr, wr_data, rd_data
  );

  // Recorder side.
  modport slave (
    input  start, abort, alu_out, rd_addr,
    output I0, I1, C, busy, done, wr_en, wr_addr, wr_data, rd_data
  );
endinterface

// File: rtl/alu_vector_recorder.sv
// ALU test-vector recorder: sweeps 256 operand combinations into an ALU,
// waits SETTLE_CYCLES, samples the result and stores 14-bit records
// {I0,I1,C,alu_out} into a 256x14 memory, mirroring each on a write strobe.
// Operand mapping: {I0[1:0],I1,C} = idx, I0[3:2] = 0.
module alu_vector_recorder #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_vector_recorder_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_IDX      = 8'hFF;

  logic [1:0]  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [13:0] wr_data_q, wr_data_d;
  logic [13:0] rd_data_q;
  logic        mem_we_s;
  logic [3:0]  i0_s;
  logic [3:0]  i1_s;
  logic [1:0]  c_s;
  logic [13:0] mem_q [0:255];

  function automatic logic [13:0] pack_record(input logic [3:0] i0,
                                              input logic [3:0] i1,
                                              input logic [1:0] c,
                                              input logic [3:0] res);
    return {i0, i1, c, res};
  endfunction

  // Operands are a fixed slice of the registered sweep index.
  assign i0_s = {2'b00, idx_q[7:6]};
  assign i1_s = idx_q[5:2];
  assign c_s  = idx_q[1:0];

  assign bus.I0      = i0_s;
  assign bus.I1      = i1_s;
  assign bus.C       = c_s;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  // A CAPTURE cycle that sees abort is cancelled, so its strobe is masked.
  assign bus.wr_en   = wr_en_q & ~bus.abort;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_data = rd_data_q;

  // Next-state logic for the sweep FSM and the record staging registers.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          idx_d   = 8'd0;
          cnt_d   = SETTLE_RELOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          idx_d   = 8'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          // Result has settled: latch the record shown during CAPTURE.
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = pack_record(i0_s, i1_s, c_s, bus.alu_out);
          state_d   = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CAPTURE: begin
        if (bus.abort) begin
          idx_d   = 8'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          mem_we_s = 1'b1;
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            cnt_d   = SETTLE_RELOAD;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = 8'd0;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sweep state and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 8'd0;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 14'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Record memory commit at the end of an uncancelled CAPTURE cycle; never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_addr_q] <= wr_data_q;
    end
  end

  // Registered read port; a same-cycle write to the same entry returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 14'd0;
    end else begin
      rd_data_q <= mem_q[bus.rd_addr];
    end
  end

endmodule

// File: tb/tb_alu_vector_recorder.sv
// Self-checking bench for alu_vector_recorder: scoreboard of expected records
// pushed at start and popped on every observed write strobe.
module tb_alu_vector_recorder;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [13:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [3:0] key;
  logic sel4;
  rec_t exp_q[$];

  logic        m_busy, m_done, m_wr_en;
  logic [7:0]  m_wr_addr;
  logic [13:0] m_wr_data;

  alu_vector_recorder_if if1();
  alu_vector_recorder_if if4();

  alu_vector_recorder #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  alu_vector_recorder #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  // ALU under test model: I1 + C, optionally scrambled by key to tell runs apart.
  assign if1.alu_out = (if1.I1 + {2'b00, if1.C}) ^ key;
  assign if4.alu_out = (if4.I1 + {2'b00, if4.C}) ^ key;

  assign m_busy    = sel4 ? if4.busy    : if1.busy;
  assign m_done    = sel4 ? if4.done    : if1.done;
  assign m_wr_en   = sel4 ? if4.wr_en   : if1.wr_en;
  assign m_wr_addr = sel4 ? if4.wr_addr : if1.wr_addr;
  assign m_wr_data = sel4 ? if4.wr_data : if1.wr_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] model(input logic [7:0] i, input logic [3:0] k);
    logic [3:0] i1;
    logic [1:0] c;
    i1 = i[5:2];
    c  = i[1:0];
    return {2'b00, i[7:6], i1, c, (i1 + {2'b00, c}) ^ k};
  endfunction

  task automatic drive_start(input logic v);
    if (sel4) if4.start = v;
    else      if1.start = v;
  endtask

  task automatic read_entry(input logic [7:0] a, output logic [13:0] d);
    @(posedge clk); #1 if1.rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    d = if1.rd_data;
  endtask

  task automatic run_sweep(input string tag, input logic use4, input int per,
                           input logic pulse_busy, input int abort_after);
    rec_t e;
    int rel, c0, done_at, busy_first, busy_last, nwr, post, budget;
    logic aborted;
    sel4 = use4;
    exp_q.delete();
    done_at = -1; busy_first = -1; busy_last = -1; nwr = 0; post = 0; aborted = 1'b0;
    budget = 256 * per + 20;
    @(posedge clk); #1;
    c0 = cyc;
    drive_start(1'b1);
    for (int i = 0; i < 256; i++) begin
      e.cyc = per * (i + 1); e.addr = 8'(i); e.data = model(8'(i), key);
      exp_q.push_back(e);
    end
    @(posedge clk); #1 drive_start(1'b0);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      rel = cyc - c0;
      drive_start(pulse_busy && m_busy && (rel % 37 == 10));
      if (m_busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (m_wr_en) begin
        nwr++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_write: got write at cycle %0d addr %02h data %04h, expected no write",
                   tag, rel, m_wr_addr, m_wr_data);
        end else begin
          e = exp_q.pop_front();
          if (rel != e.cyc || m_wr_addr !== e.addr || m_wr_data !== e.data) begin
            n_fail++;
            $display("FAIL %s_write: got cycle %0d addr %02h data %04h, expected cycle %0d addr %02h data %04h",
                     tag, rel, m_wr_addr, m_wr_data, e.cyc, e.addr, e.data);
          end
        end
      end
      if (m_done && done_at < 0) done_at = rel;
      if (done_at >= 0) break;
      if (aborted) begin
        post++;
        if (post > 20) break;
      end
      if (abort_after > 0 && !aborted && nwr == abort_after) begin
        @(posedge clk); #1 if1.abort = 1'b1;
        @(posedge clk); #1 if1.abort = 1'b0;
        aborted = 1'b1;
        exp_q.delete();
      end
    end
    drive_start(1'b0);
    if (abort_after > 0) begin
      n_cmp++;
      if (nwr != abort_after || m_busy !== 1'b0 || m_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_abort_state: got writes %0d busy %b done %b, expected writes %0d busy 0 done 0",
                 tag, nwr, m_busy, m_done, abort_after);
      end
    end else begin
      n_cmp++;
      if (done_at != 256 * per + 1) begin
        n_fail++;
        $display("FAIL %s_done_cycle: got %0d, expected %0d", tag, done_at, 256 * per + 1);
      end
      n_cmp++;
      if (busy_first != 1 || busy_last != 256 * per) begin
        n_fail++;
        $display("FAIL %s_busy_window: got %0d..%0d, expected 1..%0d", tag, busy_first, busy_last, 256 * per);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL %s_missing_writes: got %0d unwritten records, expected 0", tag, exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({if1.I0, if1.I1, if1.C, if1.busy, if1.done, if1.wr_en, if1.wr_addr, if1.wr_data, if1.rd_data} !== 49'd0) begin
      n_fail++;
      $display("FAIL reset_values: got busy %b done %b wr_en %b wr_addr %02h wr_data %04h rd_data %04h, expected all 0",
               if1.busy, if1.done, if1.wr_en, if1.wr_addr, if1.wr_data, if1.rd_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({if1.I0, if1.I1, if1.C, if1.busy, if1.done, if1.wr_en, if1.wr_addr, if1.wr_data} !== 35'd0) begin
        n_fail++;
        $display("FAIL idle_outputs: got busy %b done %b wr_en %b wr_addr %02h wr_data %04h, expected all 0",
                 if1.busy, if1.done, if1.wr_en, if1.wr_addr, if1.wr_data);
      end
    end
  endtask

  task automatic test_sweep();
    key = 4'h0;
    run_sweep("sweep1", 1'b0, 2, 1'b0, 0);
  endtask

  task automatic test_readback();
    logic [13:0] d;
    read_entry(8'h27, d);
    n_cmp++;
    if (d !== 14'h027C) begin
      n_fail++;
      $display("FAIL readback_27: got %04h, expected 027c", d);
    end
    for (int i = 0; i < 256; i++) begin
      read_entry(8'(i), d);
      n_cmp++;
      if (d !== model(8'(i), 4'h0)) begin
        n_fail++;
        $display("FAIL readback_entry: addr %02h got %04h, expected %04h", i, d, model(8'(i), 4'h0));
      end
    end
  endtask

  task automatic test_abort();
    logic [13:0] d;
    key = 4'h5;
    run_sweep("abort", 1'b0, 2, 1'b0, 100);
    read_entry(8'd99, d);
    n_cmp++;
    if (d !== model(8'd99, 4'h5)) begin
      n_fail++;
      $display("FAIL abort_entry99: got %04h, expected %04h", d, model(8'd99, 4'h5));
    end
    read_entry(8'd100, d);
    n_cmp++;
    if (d !== model(8'd100, 4'h0)) begin
      n_fail++;
      $display("FAIL abort_entry100: got %04h, expected %04h", d, model(8'd100, 4'h0));
    end
    run_sweep("restart", 1'b0, 2, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    key = 4'h0;
    run_sweep("settle4", 1'b1, 5, 1'b1, 0);
    sel4 = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    int c0;
    logic [13:0] d;
    key = 4'h9;
    sel4 = 1'b0;
    @(posedge clk); #1;
    c0 = cyc;
    if1.start = 1'b1;
    @(posedge clk); #1 if1.start = 1'b0;
    while (cyc - c0 < 300) @(negedge clk);
    n_cmp++;
    if (if1.busy !== 1'b1 || if1.wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_running: got busy %b wr_en %b, expected busy 1 wr_en 1", if1.busy, if1.wr_en);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if1.I0, if1.I1, if1.C, if1.busy, if1.done, if1.wr_en, if1.wr_addr, if1.wr_data, if1.rd_data} !== 49'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got busy %b wr_en %b wr_addr %02h wr_data %04h rd_data %04h, expected all 0",
               if1.busy, if1.wr_en, if1.wr_addr, if1.wr_data, if1.rd_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    read_entry(8'd10, d);
    n_cmp++;
    if (d !== model(8'd10, 4'h9)) begin
      n_fail++;
      $display("FAIL midreset_entry10: got %04h, expected %04h", d, model(8'd10, 4'h9));
    end
    read_entry(8'd200, d);
    n_cmp++;
    if (d !== model(8'd200, 4'h0)) begin
      n_fail++;
      $display("FAIL midreset_entry200: got %04h, expected %04h", d, model(8'd200, 4'h0));
    end
  endtask

  initial begin
    key = 4'h0;
    sel4 = 1'b0;
    if1.start = 1'b0; if1.abort = 1'b0; if1.rd_addr = 8'd0;
    if4.start = 1'b0; if4.abort = 1'b0; if4.rd_addr = 8'd0;
    test_reset();
    test_sweep();
    test_readback();
    test_abort();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
